ahb_rr_arbiter: RTL and testbench
=================================

Name: ahb_rr_arbiter

Overview:
- Clocked, parametrised AHB bus arbiter for the multi-manager interconnect; successor to the enable-strobed round-robin arbiter.
- Selects one of MANAGERS requesters in round-robin or fixed-priority mode.
- Holds the grant across locked sequences and up to a configurable quantum, and parks on a default manager when idle.
- Also tracks the data-phase owner so the data mux can follow the AHB address/data pipeline.

Parameters:
- MANAGERS, 4, number of requesting managers (>=2).
- DEFAULT_MGR, 0, manager parked on when nobody requests (0..MANAGERS-1).
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- QUANTUM, 8, max consecutive hready address phases an unlocked owner may keep the bus while others wait; 0 = unlimited.

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req  in  MANAGERS  per-manager bus request, bit i = manager i.
- lock  in  MANAGERS  per-manager HMASTLOCK request; only meaningful for the current owner.
- hready  in  1  HREADY from the selected subordinate; arbitration and pipeline advance only when 1.
- grant  out  MANAGERS  one-hot address-phase grant.
- grant_id  out  $clog2(MANAGERS)  binary index of grant.
- park  out  1  1 = grant is the idle default, not a real request.
- dphase_id  out  $clog2(MANAGERS)  manager owning the current data phase.
- hmastlock  out  1  registered lock of the address-phase owner.

Behaviour:
- Reset (HRESETn=0, async) sets:
  - grant = onehot(DEFAULT_MGR), grant_id = DEFAULT_MGR, park = 1.
  - dphase_id = DEFAULT_MGR, hmastlock = 0.
  - rr_ptr = (DEFAULT_MGR+1) mod MANAGERS, hold_cnt = 0.
- Arbitration is evaluated only on an edge where hready = 1. With hready = 0, every output and internal register holds.
- Owner is grant_id. The owner is "locked" when park = 0 and req[owner] = 1 and lock[owner] = 1.
- Decision on an hready = 1 edge, in priority order:
  1. Locked: keep owner; hold_cnt unchanged; hmastlock <= 1.
  2. Else if park = 0, req[owner] = 1, and (QUANTUM = 0 or hold_cnt < QUANTUM-1): keep owner; hold_cnt <= hold_cnt+1 (saturating).
  3. Else if req != 0: select a winner, load grant/grant_id, set park <= 0, and hold_cnt <= 0.
     - MODE 0: first set bit of req scanning rr_ptr, rr_ptr+1, ... with wrap; then rr_ptr <= (winner+1) mod MANAGERS.
     - MODE 1: lowest set bit of req; rr_ptr unchanged.
  4. Else (req = 0): grant <= onehot(DEFAULT_MGR), park <= 1, hold_cnt <= 0; rr_ptr unchanged.
- hmastlock is 0 in cases 2-4.
- An owner hitting the quantum with no other requester re-wins in case 3 with hold_cnt reset. There is no idle gap.
- Latency:
  - Request to grant: 1 cycle when hready = 1 and the bus is free.
  - Drop of req[owner] to handover: same next edge.
- Pipeline: on every hready = 1 edge, dphase_id <= grant_id (the value before the update). This gives a 1-cycle lag, matching the AHB address to data phase.
- Simultaneous events:
  - The lock rule beats the quantum rule.
  - A lock asserted by a non-owner is ignored until that manager wins.
  - req[owner] dropping while lock = 1 releases the lock on the same edge.
- Reset mid-transfer returns to the park state immediately; there is no pending grant memory.
- Widths: hold_cnt is $clog2(QUANTUM+1) bits, minimum 1. rr_ptr and ids are $clog2(MANAGERS) bits. Modulo wrap applies for non-power-of-two MANAGERS.

Test Plan (MANAGERS=4, DEFAULT_MGR=0, QUANTUM=4 unless stated):
- Reset, req=0000, hready=1 for 5 cycles -> grant=0001, park=1, dphase_id=0 throughout.
- MODE 0, req=1111 held, lock=0 -> owner sequence 1,1,1,1,2,2,2,2,3,... Each owner holds 4 hready cycles; dphase_id trails grant_id by 1 cycle.
- MODE 0, req=0110, owner 1, req[1] drops -> grant=0100 on the next edge. Then req=0010 -> grant 0010 when 2 drops, with round-robin wrapping through 3, 0 correctly.
- Owner 2 with lock[2]=1, req=1111, 10 cycles -> grant stays 0100, hmastlock=1 beyond the quantum. Clearing lock[2] with hold_cnt expired -> handover to 3 next edge.
- hready=0 for 3 cycles while owner 1 drops req and req=1000 -> grant, dphase_id, and hold_cnt frozen. First hready=1 edge -> grant=1000.
- MODE 1, QUANTUM=0, req=1010 -> grant=0010 indefinitely. Dropping req[1] -> 1000. HRESETn pulsed low mid-burst -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant with lock and quantum hold,
// idle parking on a default manager, and a data-phase owner tracking the address pipeline.
module ahb_rr_arbiter #(
  parameter int MANAGERS    = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int MODE        = 0,
  parameter int QUANTUM     = 8
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [MANAGERS-1:0]         req,
  input  logic [MANAGERS-1:0]         lock,
  input  logic                        hready,
  output logic [MANAGERS-1:0]         grant,
  output logic [$clog2(MANAGERS)-1:0] grant_id,
  output logic                        park,
  output logic [$clog2(MANAGERS)-1:0] dphase_id,
  output logic                        hmastlock
);

  localparam int IDW = $clog2(MANAGERS);
  localparam int HCW = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);
  localparam logic [IDW-1:0] DEF_ID  = IDW'(DEFAULT_MGR);
  localparam logic [IDW-1:0] RST_PTR = IDW'((DEFAULT_MGR + 1) % MANAGERS);
  localparam logic [HCW-1:0] HC_MAX  = '1;

  logic [IDW-1:0] r_grant_id;
  logic [IDW-1:0] r_dphase_id;
  logic [IDW-1:0] r_rr_ptr;
  logic [HCW-1:0] r_hold_cnt;
  logic           r_park;
  logic           r_hmastlock;

  logic           w_owner_req;
  logic           w_locked;
  logic           w_quota_ok;
  logic           w_found;
  int             w_idx;
  int             w_win;
  logic [IDW-1:0] w_win_id;
  logic [IDW-1:0] w_next_ptr;

  assign w_owner_req = !r_park && req[r_grant_id];
  assign w_locked    = w_owner_req && lock[r_grant_id];
  assign w_quota_ok  = (QUANTUM == 0) || (int'(r_hold_cnt) < QUANTUM - 1);

  // Scan starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
  always_comb begin
    w_found = 1'b0;
    w_win   = DEFAULT_MGR;
    w_idx   = 0;
    for (int k = 0; k < MANAGERS; k++) begin
      if (MODE == 1) w_idx = k;
      else           w_idx = (int'(r_rr_ptr) + k) % MANAGERS;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_id   = IDW'(w_win);
  assign w_next_ptr = IDW'((w_win + 1) % MANAGERS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant_id  <= DEF_ID;
      r_park      <= 1'b1;
      r_dphase_id <= DEF_ID;
      r_hmastlock <= 1'b0;
      r_rr_ptr    <= RST_PTR;
      r_hold_cnt  <= '0;
    end else if (hready) begin
      r_dphase_id <= r_grant_id;
      r_hmastlock <= 1'b0;
      if (w_locked) begin
        r_hmastlock <= 1'b1;
      end else if (w_owner_req && w_quota_ok) begin
        if (r_hold_cnt != HC_MAX) r_hold_cnt <= r_hold_cnt + HCW'(1);
      end else if (|req) begin
        // An owner at its quantum with no rival simply re-wins here with a fresh count.
        r_grant_id <= w_win_id;
        r_park     <= 1'b0;
        r_hold_cnt <= '0;
        if (MODE == 0) r_rr_ptr <= w_next_ptr;
      end else begin
        r_grant_id <= DEF_ID;
        r_park     <= 1'b1;
        r_hold_cnt <= '0;
      end
    end
  end

  always_comb begin
    grant             = '0;
    grant[r_grant_id] = 1'b1;
  end

  assign grant_id  = r_grant_id;
  assign park      = r_park;
  assign dphase_id = r_dphase_id;
  assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench: a round-robin instance (QUANTUM=4) and a fixed-priority instance (QUANTUM=0)
// sharing clock and reset, each checked against hand-computed grant sequences.
module tb_ahb_rr_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] reqA, lockA, reqB, lockB;
  logic       hreadyA, hreadyB;
  logic [3:0] gntA, gntB;
  logic [1:0] idA, idB, dphA, dphB;
  logic       parkA, parkB, hmlA, hmlB;

  int checkCount = 0;
  int errorCount = 0;

  always #5 HCLK = ~HCLK;

  ahb_rr_arbiter #(.MANAGERS(4), .DEFAULT_MGR(0), .MODE(0), .QUANTUM(4)) dutRr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(reqA), .lock(lockA), .hready(hreadyA),
    .grant(gntA), .grant_id(idA), .park(parkA), .dphase_id(dphA), .hmastlock(hmlA)
  );

  ahb_rr_arbiter #(.MANAGERS(4), .DEFAULT_MGR(0), .MODE(1), .QUANTUM(0)) dutFp (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(reqB), .lock(lockB), .hready(hreadyB),
    .grant(gntB), .grant_id(idB), .park(parkB), .dphase_id(dphB), .hmastlock(hmlB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic h);
    @(negedge HCLK);
    reqA = r; lockA = l; hreadyA = h;
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulusFixed(input logic [3:0] r, input logic [3:0] l, input logic h);
    @(negedge HCLK);
    reqB = r; lockB = l; hreadyB = h;
    @(posedge HCLK);
    #1;
  endtask

  task automatic doReset();
    @(negedge HCLK);
    HRESETn = 1'b0;
    reqA = '0; lockA = '0; hreadyA = 1'b0;
    reqB = '0; lockB = '0; hreadyB = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  int expId[17] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0, 1};
  int prevId;

  initial begin
    HRESETn = 1'b0;
    reqA = '0; lockA = '0; hreadyA = 1'b0;
    reqB = '0; lockB = '0; hreadyB = 1'b0;
    #12;
    checkOutput("reset grant", gntA, 4'b0001);
    checkOutput("reset park", parkA, 1'b1);
    checkOutput("reset hmastlock", hmlA, 1'b0);
    doReset();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput($sformatf("idle grant %0d", i), gntA, 4'b0001);
      checkOutput($sformatf("idle park %0d", i), parkA, 1'b1);
      checkOutput($sformatf("idle dphase %0d", i), dphA, 2'd0);
    end

    doReset();
    prevId = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkOutput($sformatf("rr id %0d", i), idA, 32'(expId[i]));
      checkOutput($sformatf("rr grant %0d", i), gntA, 32'(1 << expId[i]));
      checkOutput($sformatf("rr dphase %0d", i), dphA, 32'(prevId));
      checkOutput($sformatf("rr park %0d", i), parkA, 1'b0);
      prevId = expId[i];
    end

    doReset();
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    checkOutput("drop first win", gntA, 4'b0010);
    applyStimulus(4'b0110, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    checkOutput("drop handover", gntA, 4'b0100);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("wrap to 1", gntA, 4'b0010);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("wrap to 0", gntA, 4'b0001);
    checkOutput("wrap to 0 park", parkA, 1'b0);

    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("lock owner 1", idA, 2'd1);
    applyStimulus(4'b1100, 4'b0100, 1'b1);
    checkOutput("lock owner 2", idA, 2'd2);
    checkOutput("non-owner lock ignored", hmlA, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("lock pre-quantum", idA, 2'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1111, 4'b0100, 1'b1);
      checkOutput($sformatf("locked grant %0d", i), gntA, 4'b0100);
      checkOutput($sformatf("locked hmastlock %0d", i), hmlA, 1'b1);
    end
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    checkOutput("unlock handover", gntA, 4'b1000);
    checkOutput("unlock hmastlock", hmlA, 1'b0);
    applyStimulus(4'b1111, 4'b1000, 1'b1);
    checkOutput("lock owner 3", hmlA, 1'b1);
    applyStimulus(4'b0111, 4'b1000, 1'b1);
    checkOutput("req drop releases lock", gntA, 4'b0001);
    checkOutput("req drop hmastlock", hmlA, 1'b0);

    doReset();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("pre-freeze dphase", dphA, 2'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      checkOutput($sformatf("freeze grant %0d", i), gntA, 4'b0010);
      checkOutput($sformatf("freeze dphase %0d", i), dphA, 2'd1);
    end
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    checkOutput("thaw grant", gntA, 4'b1000);
    checkOutput("thaw dphase", dphA, 2'd1);
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    checkOutput("thaw dphase next", dphA, 2'd3);

    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulusFixed(4'b1010, 4'b0000, 1'b1);
      checkOutput($sformatf("fixed grant %0d", i), gntB, 4'b0010);
    end
    applyStimulusFixed(4'b1011, 4'b0000, 1'b1);
    checkOutput("fixed owner keeps", gntB, 4'b0010);
    applyStimulusFixed(4'b1001, 4'b0000, 1'b1);
    checkOutput("fixed lowest wins", gntB, 4'b0001);
    checkOutput("fixed not parked", parkB, 1'b0);
    applyStimulusFixed(4'b1000, 4'b0000, 1'b1);
    checkOutput("fixed to 3", gntB, 4'b1000);
    applyStimulusFixed(4'b1000, 4'b0000, 1'b1);
    checkOutput("fixed dphase", dphB, 2'd3);

    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("async reset grant", gntB, 4'b0001);
    checkOutput("async reset id", idB, 2'd0);
    checkOutput("async reset park", parkB, 1'b1);
    checkOutput("async reset dphase", dphB, 2'd0);
    checkOutput("async reset hmastlock", hmlB, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
